// File: rtl/cr_huf_comp_sc_short_drain.sv
// Short-symbol FIFO drain: turns each compacted entry into per-slot histogram
// increment requests and reports per-block totals, the block id and seq_id errors.
module cr_huf_comp_sc_short_drain #(
  parameter int SYM_W = 10,
  parameter int TOT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             short_vld,
  output logic             short_rd,
  input  logic [SYM_W-1:0] short0,
  input  logic [SYM_W-1:0] short1,
  input  logic [SYM_W-1:0] short2,
  input  logic [SYM_W-1:0] short3,
  input  logic [2:0]       cnt0,
  input  logic [2:0]       cnt1,
  input  logic [2:0]       cnt2,
  input  logic [2:0]       cnt3,
  input  logic [3:0]       seq_id,
  input  logic [1:0]       eob,
  output logic             inc_vld,
  output logic [SYM_W-1:0] inc_sym,
  output logic [2:0]       inc_amt,
  input  logic             inc_rdy,
  output logic             blk_done,
  output logic [3:0]       blk_seq_id,
  output logic [TOT_W-1:0] blk_sym_tot,
  output logic             seq_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    CAP   = 3'd2,
    ISSUE = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [SYM_W-1:0] sym_q [4];
  logic [SYM_W-1:0] sym_d [4];
  logic [2:0]       cnt_q [4];
  logic [2:0]       cnt_d [4];
  logic [1:0]       eob_q, eob_d;
  logic [3:0]       blk_id_q, blk_id_d;
  logic             first_q, first_d;
  logic [TOT_W-1:0] acc_q, acc_d;
  logic             seq_err_d;

  logic             short_rd_q, inc_vld_q, blk_done_q, seq_err_q;
  logic [SYM_W-1:0] inc_sym_q;
  logic [2:0]       inc_amt_q;
  logic [3:0]       blk_seq_id_q;
  logic [TOT_W-1:0] blk_sym_tot_q;

  logic [SYM_W-1:0] in_sym_s [4];
  logic [2:0]       in_cnt_s [4];
  logic [3:0]       nz_in_s, nz_q_s;
  logic [2:0]       slot_s;
  logic [TOT_W:0]   sum_s;

  assign in_sym_s[0] = short0;
  assign in_sym_s[1] = short1;
  assign in_sym_s[2] = short2;
  assign in_sym_s[3] = short3;
  assign in_cnt_s[0] = cnt0;
  assign in_cnt_s[1] = cnt1;
  assign in_cnt_s[2] = cnt2;
  assign in_cnt_s[3] = cnt3;

  // Lowest slot at or above 'from' holding a nonzero count; returns {found, index}.
  function automatic logic [2:0] find_slot(input logic [3:0] nz, input logic [2:0] from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (nz[i] && (3'(i) >= from)) begin
        r = {1'b1, 2'(i)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Per-slot nonzero masks and saturating accumulator sum
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      nz_in_s[i] = (in_cnt_s[i] != 3'd0);
      nz_q_s[i]  = (cnt_q[i] != 3'd0);
    end
    sum_s = {1'b0, acc_q} + (TOT_W+1)'(cnt_q[idx_q]);
  end

  // Next-state and datapath decode
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sym_d     = sym_q;
    cnt_d     = cnt_q;
    eob_d     = eob_q;
    blk_id_d  = blk_id_q;
    first_d   = first_q;
    acc_d     = acc_q;
    seq_err_d = 1'b0;
    slot_s    = 3'b000;
    case (state_q)
      IDLE: begin
        if (short_vld) begin
          state_d = RD;
        end else begin
          state_d = IDLE;
        end
      end
      RD: state_d = CAP;
      CAP: begin
        sym_d = in_sym_s;
        cnt_d = in_cnt_s;
        eob_d = eob;
        if (first_q) begin
          blk_id_d = seq_id;
          first_d  = 1'b0;
        end else begin
          seq_err_d = (seq_id != blk_id_q);
        end
        slot_s = find_slot(nz_in_s, 3'd0);
        if (slot_s[2]) begin
          idx_d   = slot_s[1:0];
          state_d = ISSUE;
        end else begin
          idx_d   = 2'd0;
          state_d = (eob != 2'b00) ? DONE : IDLE;
        end
      end
      ISSUE: begin
        if (inc_rdy) begin
          acc_d  = sum_s[TOT_W] ? {TOT_W{1'b1}} : sum_s[TOT_W-1:0];
          slot_s = find_slot(nz_q_s, {1'b0, idx_q} + 3'd1);
          if (slot_s[2]) begin
            idx_d = slot_s[1:0];
          end else begin
            idx_d   = 2'd0;
            state_d = (eob_q != 2'b00) ? DONE : IDLE;
          end
        end else begin
          state_d = ISSUE;
        end
      end
      DONE: begin
        acc_d   = {TOT_W{1'b0}};
        first_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured entry and registered outputs (outputs follow the next state)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= 2'd0;
      sym_q         <= '{default: '0};
      cnt_q         <= '{default: '0};
      eob_q         <= 2'b00;
      blk_id_q      <= 4'd0;
      first_q       <= 1'b1;
      acc_q         <= {TOT_W{1'b0}};
      short_rd_q    <= 1'b0;
      inc_vld_q     <= 1'b0;
      inc_sym_q     <= {SYM_W{1'b0}};
      inc_amt_q     <= 3'd0;
      blk_done_q    <= 1'b0;
      blk_seq_id_q  <= 4'd0;
      blk_sym_tot_q <= {TOT_W{1'b0}};
      seq_err_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sym_q      <= sym_d;
      cnt_q      <= cnt_d;
      eob_q      <= eob_d;
      blk_id_q   <= blk_id_d;
      first_q    <= first_d;
      acc_q      <= acc_d;
      short_rd_q <= (state_d == RD);
      inc_vld_q  <= (state_d == ISSUE);
      inc_sym_q  <= (state_d == ISSUE) ? sym_d[idx_d] : {SYM_W{1'b0}};
      inc_amt_q  <= (state_d == ISSUE) ? cnt_d[idx_d] : 3'd0;
      blk_done_q <= (state_d == DONE);
      seq_err_q  <= seq_err_d;
      if (state_d == DONE) begin
        blk_seq_id_q  <= blk_id_d;
        blk_sym_tot_q <= acc_d;
      end else begin
        blk_seq_id_q  <= blk_seq_id_q;
        blk_sym_tot_q <= blk_sym_tot_q;
      end
    end
  end

  assign short_rd    = short_rd_q;
  assign inc_vld     = inc_vld_q;
  assign inc_sym     = inc_sym_q;
  assign inc_amt     = inc_amt_q;
  assign blk_done    = blk_done_q;
  assign blk_seq_id  = blk_seq_id_q;
  assign blk_sym_tot = blk_sym_tot_q;
  assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_cr_huf_comp_sc_short_drain.sv
// Directed bench for the short-symbol drain: FIFO read handshake, increment
// sequencing, backpressure, zero-slot skipping, block totals, seq_err and reset.
module tb_cr_huf_comp_sc_short_drain;
  localparam int SYM_W = 10;
  localparam int TOT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             short_vld;
  logic             short_rd;
  logic [SYM_W-1:0] short0, short1, short2, short3;
  logic [2:0]       cnt0, cnt1, cnt2, cnt3;
  logic [3:0]       seq_id;
  logic [1:0]       eob;
  logic             inc_vld;
  logic [SYM_W-1:0] inc_sym;
  logic [2:0]       inc_amt;
  logic             inc_rdy;
  logic             blk_done;
  logic [3:0]       blk_seq_id;
  logic [TOT_W-1:0] blk_sym_tot;
  logic             seq_err;

  int n_tests = 0;
  int n_fail  = 0;

  cr_huf_comp_sc_short_drain #(.SYM_W(SYM_W), .TOT_W(TOT_W)) dut (
    .clk(clk), .rst(rst), .short_vld(short_vld), .short_rd(short_rd),
    .short0(short0), .short1(short1), .short2(short2), .short3(short3),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3),
    .seq_id(seq_id), .eob(eob),
    .inc_vld(inc_vld), .inc_sym(inc_sym), .inc_amt(inc_amt), .inc_rdy(inc_rdy),
    .blk_done(blk_done), .blk_seq_id(blk_seq_id), .blk_sym_tot(blk_sym_tot),
    .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Present one FIFO entry and wait (bounded) for the single read strobe.
  task automatic send_entry(input logic [SYM_W-1:0] s0, input logic [SYM_W-1:0] s1,
                            input logic [SYM_W-1:0] s2, input logic [SYM_W-1:0] s3,
                            input logic [2:0] c0, input logic [2:0] c1,
                            input logic [2:0] c2, input logic [2:0] c3,
                            input logic [3:0] sid, input logic [1:0] e);
    logic seen;
    short0 = s0; short1 = s1; short2 = s2; short3 = s3;
    cnt0 = c0; cnt1 = c1; cnt2 = c2; cnt3 = c3;
    seq_id = sid; eob = e;
    short_vld = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (short_rd) seen = 1'b1;
    end
    short_vld = 1'b0;
    check_val("rd_strobe", 32'(seen), 32'd1);
    // CAP cycle: nothing issued yet, read strobe already gone
    @(negedge clk);
    check_val("cap_no_inc", 32'(inc_vld), 32'd0);
    check_val("cap_no_rd", 32'(short_rd), 32'd0);
  endtask

  task automatic expect_inc(input logic [SYM_W-1:0] s, input logic [2:0] a);
    @(negedge clk);
    check_val("inc_vld", 32'(inc_vld), 32'd1);
    check_val("inc_sym", 32'(inc_sym), 32'(s));
    check_val("inc_amt", 32'(inc_amt), 32'(a));
  endtask

  task automatic expect_done(input logic [3:0] sid, input logic [15:0] tot);
    @(negedge clk);
    check_val("blk_done", 32'(blk_done), 32'd1);
    check_val("inc_vld_off", 32'(inc_vld), 32'd0);
    check_val("blk_seq_id", 32'(blk_seq_id), 32'(sid));
    check_val("blk_sym_tot", 32'(blk_sym_tot), 32'(tot));
    @(negedge clk);
    check_val("blk_done_pulse", 32'(blk_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; short_vld = 1'b0; inc_rdy = 1'b1;
    short0 = 10'd0; short1 = 10'd0; short2 = 10'd0; short3 = 10'd0;
    cnt0 = 3'd0; cnt1 = 3'd0; cnt2 = 3'd0; cnt3 = 3'd0;
    seq_id = 4'd0; eob = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state and idle with no FIFO data
    check_val("rst_inc_sym", 32'(inc_sym), 32'd0);
    check_val("rst_inc_amt", 32'(inc_amt), 32'd0);
    check_val("rst_seq_id", 32'(blk_seq_id), 32'd0);
    check_val("rst_tot", 32'(blk_sym_tot), 32'd0);
    check_val("rst_seq_err", 32'(seq_err), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_val("idle_rd", 32'(short_rd), 32'd0);
      check_val("idle_inc", 32'(inc_vld), 32'd0);
      check_val("idle_done", 32'(blk_done), 32'd0);
    end

    // Single-entry block, always ready
    send_entry(10'd5, 10'd9, 10'd12, 10'd0, 3'd1, 3'd2, 3'd1, 3'd0, 4'd3, 2'b01);
    expect_inc(10'd5, 3'd1);
    check_val("single_seq_err", 32'(seq_err), 32'd0);
    expect_inc(10'd9, 3'd2);
    expect_inc(10'd12, 3'd1);
    expect_done(4'd3, 16'd4);

    // Backpressure at slot 1: request held for 4 cycles
    send_entry(10'd5, 10'd9, 10'd12, 10'd0, 3'd1, 3'd2, 3'd1, 3'd0, 4'd3, 2'b01);
    expect_inc(10'd5, 3'd1);
    expect_inc(10'd9, 3'd2);
    inc_rdy = 1'b0;
    for (int i = 0; i < 3; i++) expect_inc(10'd9, 3'd2);
    inc_rdy = 1'b1;
    expect_inc(10'd12, 3'd1);
    expect_done(4'd3, 16'd4);

    // Non-contiguous zero-count slots
    send_entry(10'd100, 10'd200, 10'd300, 10'd400, 3'd0, 3'd3, 3'd0, 3'd1, 4'd1, 2'b01);
    expect_inc(10'd200, 3'd3);
    expect_inc(10'd400, 3'd1);
    expect_done(4'd1, 16'd4);

    // All-zero entry ending the block
    send_entry(10'd1, 10'd2, 10'd3, 10'd4, 3'd0, 3'd0, 3'd0, 3'd0, 4'd2, 2'b01);
    expect_done(4'd2, 16'd0);

    // Multi-entry block with a seq_id change on the last entry
    send_entry(10'd1, 10'd2, 10'd3, 10'd4, 3'd1, 3'd1, 3'd1, 3'd1, 4'd7, 2'b00);
    expect_inc(10'd1, 3'd1);
    check_val("multi_a_seq_err", 32'(seq_err), 32'd0);
    expect_inc(10'd2, 3'd1);
    expect_inc(10'd3, 3'd1);
    expect_inc(10'd4, 3'd1);
    @(negedge clk);
    check_val("multi_a_no_done", 32'(blk_done), 32'd0);
    send_entry(10'd20, 10'd21, 10'd0, 10'd0, 3'd2, 3'd2, 3'd0, 3'd0, 4'd7, 2'b00);
    expect_inc(10'd20, 3'd2);
    check_val("multi_b_seq_err", 32'(seq_err), 32'd0);
    expect_inc(10'd21, 3'd2);
    @(negedge clk);
    check_val("multi_b_no_done", 32'(blk_done), 32'd0);
    send_entry(10'd0, 10'd0, 10'd30, 10'd31, 3'd0, 3'd0, 3'd1, 3'd1, 4'd8, 2'b10);
    expect_inc(10'd30, 3'd1);
    check_val("multi_c_seq_err", 32'(seq_err), 32'd1);
    expect_inc(10'd31, 3'd1);
    check_val("seq_err_pulse", 32'(seq_err), 32'd0);
    expect_done(4'd7, 16'd10);

    // Reset while issuing slot 2
    send_entry(10'd10, 10'd11, 10'd12, 10'd13, 3'd1, 3'd1, 3'd1, 3'd1, 4'd9, 2'b01);
    expect_inc(10'd10, 3'd1);
    expect_inc(10'd11, 3'd1);
    expect_inc(10'd12, 3'd1);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_mid_inc", 32'(inc_vld), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("rst_mid_no_done", 32'(blk_done), 32'd0);
      check_val("rst_mid_no_inc", 32'(inc_vld), 32'd0);
    end
    send_entry(10'd50, 10'd0, 10'd0, 10'd0, 3'd2, 3'd0, 3'd0, 3'd0, 4'd4, 2'b01);
    expect_inc(10'd50, 3'd2);
    check_val("post_rst_seq_err", 32'(seq_err), 32'd0);
    expect_done(4'd4, 16'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
